axi4lite_cmd_master: RTL

Upstream stage for axi4lite_slave. Converts a simple single-beat command/response handshake into AXI4-Lite master transactions on the AW/W/B/AR/R channels. Lets on-chip logic, or a bench without the vendor VIP, drive the slave directly. One transaction outstanding at a time. A read-wait/write-response timeout prevents lock-up against a dead slave.

---
 rtl/axi4lite_cmd_master.sv | 198 +++++++++++++++++++
 1 files changed

// File: rtl/axi4lite_cmd_master.sv
// Single-outstanding command/response front end that issues AXI4-Lite master
// transactions, with an optional B/R wait timeout that forces a SLVERR response.
module axi4lite_cmd_master #(
   parameter int unsigned ADDR_WIDTH = 32,
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned TIMEOUT    = 256
) (
   input  logic                  A_CLK,
   input  logic                  A_RSTn,
   input  logic                  CMD_VALID,
   output logic                  CMD_READY,
   input  logic                  CMD_WE,
   input  logic [ADDR_WIDTH-1:0] CMD_ADDR,
   input  logic [DATA_WIDTH-1:0] CMD_WDATA,
   output logic                  RSP_VALID,
   input  logic                  RSP_READY,
   output logic                  RSP_WE,
   output logic [DATA_WIDTH-1:0] RSP_RDATA,
   output logic [1:0]            RSP_RESP,
   output logic                  RSP_TIMEOUT,
   output logic                  AW_VALID,
   input  logic                  AW_READY,
   output logic [ADDR_WIDTH-1:0] AW_ADDR,
   output logic                  W_VALID,
   input  logic                  W_READY,
   output logic [DATA_WIDTH-1:0] W_DATA,
   input  logic                  B_VALID,
   output logic                  B_READY,
   input  logic [1:0]            B_RESP,
   output logic                  AR_VALID,
   input  logic                  AR_READY,
   output logic [ADDR_WIDTH-1:0] AR_ADDR,
   input  logic                  R_VALID,
   output logic                  R_READY,
   input  logic [DATA_WIDTH-1:0] R_DATA,
   input  logic [1:0]            R_RESP
);

   localparam int unsigned CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

   typedef enum logic [2:0] {IDLE, WR_REQ, WR_RESP, RD_REQ, RD_DATA, RSP} state_t;

   state_t                state_q, state_d;
   logic                  cmd_ready_q, cmd_ready_d;
   logic                  aw_valid_q, aw_valid_d;
   logic                  w_valid_q, w_valid_d;
   logic                  b_ready_q, b_ready_d;
   logic                  ar_valid_q, ar_valid_d;
   logic                  r_ready_q, r_ready_d;
   logic                  rsp_valid_q, rsp_valid_d;
   logic                  rsp_we_q, rsp_we_d;
   logic                  rsp_timeout_q, rsp_timeout_d;
   logic [1:0]            rsp_resp_q, rsp_resp_d;
   logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
   logic [CW-1:0]         cnt_q, cnt_d;
   logic                  timeout_hit;

   assign timeout_hit = (TIMEOUT != 0) && (cnt_q == CNT_LAST);

   always_comb begin
      state_d       = state_q;
      aw_valid_d    = aw_valid_q;
      w_valid_d     = w_valid_q;
      b_ready_d     = b_ready_q;
      ar_valid_d    = ar_valid_q;
      r_ready_d     = r_ready_q;
      rsp_valid_d   = rsp_valid_q;
      rsp_we_d      = rsp_we_q;
      rsp_timeout_d = rsp_timeout_q;
      rsp_resp_d    = rsp_resp_q;
      rsp_rdata_d   = rsp_rdata_q;
      addr_d        = addr_q;
      wdata_d       = wdata_q;
      cnt_d         = cnt_q;
      case (state_q)
         IDLE: begin
            if (CMD_VALID && cmd_ready_q) begin
               addr_d   = CMD_ADDR;
               wdata_d  = CMD_WDATA;
               rsp_we_d = CMD_WE;
               if (CMD_WE) begin
                  state_d    = WR_REQ;
                  aw_valid_d = 1'b1;
                  w_valid_d  = 1'b1;
               end else begin
                  state_d    = RD_REQ;
                  ar_valid_d = 1'b1;
               end
            end
         end
         WR_REQ: begin
            // A cleared valid doubles as that channel's accept flag.
            aw_valid_d = aw_valid_q && !AW_READY;
            w_valid_d  = w_valid_q && !W_READY;
            if (!aw_valid_d && !w_valid_d) begin
               state_d   = WR_RESP;
               b_ready_d = 1'b1;
               cnt_d     = '0;
            end
         end
         WR_RESP: begin
            if (B_VALID || timeout_hit) begin
               state_d       = RSP;
               b_ready_d     = 1'b0;
               rsp_valid_d   = 1'b1;
               rsp_rdata_d   = '0;
               rsp_timeout_d = !B_VALID;
               rsp_resp_d    = B_VALID ? B_RESP : 2'b10;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         RD_REQ: begin
            if (AR_READY) begin
               state_d    = RD_DATA;
               ar_valid_d = 1'b0;
               r_ready_d  = 1'b1;
               cnt_d      = '0;
            end
         end
         RD_DATA: begin
            if (R_VALID || timeout_hit) begin
               state_d       = RSP;
               r_ready_d     = 1'b0;
               rsp_valid_d   = 1'b1;
               rsp_timeout_d = !R_VALID;
               rsp_rdata_d   = R_VALID ? R_DATA : '0;
               rsp_resp_d    = R_VALID ? R_RESP : 2'b10;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         RSP: begin
            if (RSP_READY) begin
               state_d     = IDLE;
               rsp_valid_d = 1'b0;
            end
         end
         default: state_d = IDLE;
      endcase
      cmd_ready_d = (state_d == IDLE);
   end

   always_ff @(posedge A_CLK or negedge A_RSTn) begin
      if (!A_RSTn) begin
         state_q       <= IDLE;
         cmd_ready_q   <= 1'b0;
         aw_valid_q    <= 1'b0;
         w_valid_q     <= 1'b0;
         b_ready_q     <= 1'b0;
         ar_valid_q    <= 1'b0;
         r_ready_q     <= 1'b0;
         rsp_valid_q   <= 1'b0;
         rsp_we_q      <= 1'b0;
         rsp_timeout_q <= 1'b0;
         rsp_resp_q    <= '0;
         rsp_rdata_q   <= '0;
         addr_q        <= '0;
         wdata_q       <= '0;
         cnt_q         <= '0;
      end else begin
         state_q       <= state_d;
         cmd_ready_q   <= cmd_ready_d;
         aw_valid_q    <= aw_valid_d;
         w_valid_q     <= w_valid_d;
         b_ready_q     <= b_ready_d;
         ar_valid_q    <= ar_valid_d;
         r_ready_q     <= r_ready_d;
         rsp_valid_q   <= rsp_valid_d;
         rsp_we_q      <= rsp_we_d;
         rsp_timeout_q <= rsp_timeout_d;
         rsp_resp_q    <= rsp_resp_d;
         rsp_rdata_q   <= rsp_rdata_d;
         addr_q        <= addr_d;
         wdata_q       <= wdata_d;
         cnt_q         <= cnt_d;
      end
   end

   assign CMD_READY   = cmd_ready_q;
   assign RSP_VALID   = rsp_valid_q;
   assign RSP_WE      = rsp_we_q;
   assign RSP_RDATA   = rsp_rdata_q;
   assign RSP_RESP    = rsp_resp_q;
   assign RSP_TIMEOUT = rsp_timeout_q;
   assign AW_VALID    = aw_valid_q;
   assign AW_ADDR     = addr_q;
   assign W_VALID     = w_valid_q;
   assign W_DATA      = wdata_q;
   assign B_READY     = b_ready_q;
   assign AR_VALID    = ar_valid_q;
   assign AR_ADDR     = addr_q;
   assign R_READY     = r_ready_q;

endmodule
